// File: rtl/axis_width_upsizer.sv
// ----------------------------------------------------------------------------
// axis_width_upsizer
//
// AXI-Stream width upsizer. Packs RATIO consecutive IN_WIDTH-bit input beats
// into one OUT_WIDTH-bit output beat. The first beat of a word goes to the
// lowest lane. Input TLAST flushes a partial word: unfilled upper lanes are
// zero-padded, and TLAST is forwarded on the output word.
//
// Optional feature (macro AXIS_UPSIZE_TKEEP_EN):
//   When the macro is defined, a byte-valid mask AXIS_TX_TKEEP is generated.
//   Each filled lane contributes IN_WIDTH/8 ones. When the macro is undefined,
//   neither the port nor its register exists.
//
// Parameters:
//   IN_WIDTH   input beat width in bits (multiple of 8)
//   RATIO      input beats per output beat (2..16)
//   OUT_WIDTH  IN_WIDTH*RATIO, derived
//
// Ports:
//   clk             clock, rising edge
//   resetn          asynchronous active-low reset
//   AXIS_RX_TDATA   input data
//   AXIS_RX_TVALID  input valid
//   AXIS_RX_TLAST   input end of packet
//   AXIS_RX_TREADY  input ready
//   AXIS_TX_TDATA   packed output data
//   AXIS_TX_TKEEP   output byte-valid mask (only with AXIS_UPSIZE_TKEEP_EN)
//   AXIS_TX_TVALID  output valid
//   AXIS_TX_TLAST   output end of packet
//   AXIS_TX_TREADY  output ready
// ----------------------------------------------------------------------------
module axis_width_upsizer #(
  parameter int unsigned IN_WIDTH = 256,
  parameter int unsigned RATIO    = 2,
  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [IN_WIDTH-1:0]    AXIS_RX_TDATA,
  input  logic                   AXIS_RX_TVALID,
  input  logic                   AXIS_RX_TLAST,
  output logic                   AXIS_RX_TREADY,
  output logic [OUT_WIDTH-1:0]   AXIS_TX_TDATA,
`ifdef AXIS_UPSIZE_TKEEP_EN
  output logic [OUT_WIDTH/8-1:0] AXIS_TX_TKEEP,
`endif
  output logic                   AXIS_TX_TVALID,
  output logic                   AXIS_TX_TLAST,
  input  logic                   AXIS_TX_TREADY
);

  localparam int unsigned LaneW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned LaneBytes = IN_WIDTH / 8;
  localparam logic [LaneW-1:0] LastLane = LaneW'(RATIO - 1);

  // Accumulator only needs RATIO-1 lanes: the completing beat goes straight
  // into the output register.
  logic [IN_WIDTH-1:0]  acc_q [RATIO-1];
  logic [LaneW-1:0]     lane_q, lane_d;

  logic                 out_full_q, out_full_d;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 last_q;

  logic                 rx_fire;
  logic                 completes;
  logic                 load;
  logic                 tx_fire;
  logic [OUT_WIDTH-1:0] load_data;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // A non-completing beat can always go into the accumulator. A completing
  // beat needs the output register to be empty or draining this cycle.
  assign AXIS_RX_TREADY = resetn &
                          ((~out_full_q | AXIS_TX_TREADY) |
                           ((lane_q < LastLane) & ~AXIS_RX_TLAST));

  assign rx_fire   = AXIS_RX_TVALID & AXIS_RX_TREADY;
  assign completes = (lane_q == LastLane) | AXIS_RX_TLAST;
  assign load      = rx_fire & completes;
  assign tx_fire   = out_full_q & AXIS_TX_TREADY;

  // ---------------------------------------------------------------------------
  // Output word assembly: lanes below the current lane come from the
  // accumulator, the incoming beat fills the current lane, and higher lanes
  // are zero. Stale accumulator data never leaks into padded lanes.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_data = '0;
    for (int unsigned i = 0; i < RATIO - 1; i++) begin
      if (LaneW'(i) < lane_q) begin
        load_data[i*IN_WIDTH +: IN_WIDTH] = acc_q[i];
      end
    end
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (LaneW'(i) == lane_q) begin
        load_data[i*IN_WIDTH +: IN_WIDTH] = AXIS_RX_TDATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for lane counter and output occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_d = lane_q;
    if (rx_fire) begin
      lane_d = completes ? '0 : lane_q + LaneW'(1);
    end
  end

  // A load in the same cycle as a drain keeps the register full.
  always_comb begin
    out_full_d = out_full_q;
    if (load) begin
      out_full_d = 1'b1;
    end else if (tx_fire) begin
      out_full_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator: written only by non-completing beats, so lane_q < RATIO-1.
  // Contents are never observed before being written, so no reset is needed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rx_fire && !completes) begin
      for (int unsigned i = 0; i < RATIO - 1; i++) begin
        if (LaneW'(i) == lane_q) begin
          acc_q[i] <= AXIS_RX_TDATA;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q     <= '0;
      out_full_q <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      out_full_q <= out_full_d;
      if (load) begin
        data_q <= load_data;
        last_q <= AXIS_RX_TLAST;
      end
    end
  end

`ifdef AXIS_UPSIZE_TKEEP_EN
  logic [OUT_WIDTH/8-1:0] keep_q;
  logic [OUT_WIDTH/8-1:0] load_keep;

  // Lanes 0..lane_q are filled; everything above is padding.
  always_comb begin
    load_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (LaneW'(i) <= lane_q) begin
        load_keep[i*LaneBytes +: LaneBytes] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keep_q <= '0;
    end else if (load) begin
      keep_q <= load_keep;
    end
  end

  assign AXIS_TX_TKEEP = keep_q;
`endif

  assign AXIS_TX_TDATA  = data_q;
  assign AXIS_TX_TLAST  = last_q;
  assign AXIS_TX_TVALID = out_full_q;

endmodule
